// File: rtl/image_loader_if.sv
// Word-stream handshake between an image source and the image loader.
interface image_loader_if;
  localparam int unsigned WordW = 32;

  logic [WordW-1:0] word_i;
  logic             word_valid_i;
  logic             word_ready_o;

  modport master (output word_i, output word_valid_i, input word_ready_o);
  modport slave  (input word_i, input word_valid_i, output word_ready_o);
endinterface

// File: rtl/image_loader.sv
// Streams instruction and data images into byte-wide memories, then releases CPU reset.
// Optional LOADER_DM_CLEAR_EN: zero-fills the data-memory tail after the data image.
module image_loader (
  input  logic                 clk_i,
  input  logic                 rst_i,
  image_loader_if.slave        s_if,
  output logic                 im_we_o,
  output logic [9:0]           im_addr_o,
  output logic [7:0]           im_byte_o,
  output logic                 dm_we_o,
  output logic [9:0]           dm_addr_o,
  output logic [7:0]           dm_byte_o,
  output logic                 pc_load_o,
  output logic [31:0]          pc_init_o,
  output logic                 sp_load_o,
  output logic [31:0]          sp_init_o,
  output logic                 cpu_rst_n_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int unsigned WordW     = 32;
  localparam int unsigned AddrW     = 10;
  localparam int unsigned ByteW     = 8;
  localparam int unsigned ChkW      = 35;
  localparam int unsigned MemBytes  = 1024;
  localparam int unsigned MaxDWords = 256;

  typedef enum logic [3:0] {
    I_PC, I_CNT, I_WORD, I_BYTE, D_SP, D_CNT, D_WORD, D_BYTE,
`ifdef LOADER_DM_CLEAR_EN
    D_CLEAR,
`endif
    DONE, ERR
  } state_e;

`ifdef LOADER_DM_CLEAR_EN
  localparam state_e TailState = D_CLEAR;
`else
  localparam state_e TailState = DONE;
`endif

  state_e             state_q, state_d;
  logic [AddrW-1:0]   ptr_q, ptr_d;
  logic [1:0]         bidx_q, bidx_d;
  logic [WordW-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]   n_q, n_d;
  logic [WordW-1:0]   word_q, word_d;

  logic               ready_q, ready_d;
  logic               im_we_q, im_we_d, dm_we_q, dm_we_d;
  logic [AddrW-1:0]   im_addr_q, im_addr_d, dm_addr_q, dm_addr_d;
  logic [ByteW-1:0]   im_byte_q, im_byte_d, dm_byte_q, dm_byte_d;
  logic               pc_load_q, pc_load_d, sp_load_q, sp_load_d;
  logic [WordW-1:0]   pc_init_q, pc_init_d, sp_init_q, sp_init_d;
  logic               cpu_rst_n_q, cpu_rst_n_d, done_q, done_d, err_q, err_d;

  logic               accept;
  logic [ByteW-1:0]   byte_sel;
  logic               last_word;

  assign accept    = s_if.word_valid_i && ready_q;
  // Big-endian: byte index 0 selects word[31:24].
  assign byte_sel  = ByteW'(word_q >> {~bidx_q, 3'b000});
  assign last_word = (cnt_q + WordW'(1)) == n_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= I_PC;
      ptr_q       <= '0;
      bidx_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      word_q      <= '0;
      ready_q     <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_byte_q   <= '0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_byte_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_init_q   <= '0;
      sp_load_q   <= 1'b0;
      sp_init_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bidx_q      <= bidx_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      word_q      <= word_d;
      ready_q     <= ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_byte_q   <= im_byte_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_byte_q   <= dm_byte_d;
      pc_load_q   <= pc_load_d;
      pc_init_q   <= pc_init_d;
      sp_load_q   <= sp_load_d;
      sp_init_q   <= sp_init_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bidx_d    = bidx_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    word_d    = word_q;
    im_we_d   = 1'b0;
    im_addr_d = ptr_q;
    im_byte_d = byte_sel;
    dm_we_d   = 1'b0;
    dm_addr_d = ptr_q;
    dm_byte_d = byte_sel;
    pc_load_d = 1'b0;
    pc_init_d = pc_init_q;
    sp_load_d = 1'b0;
    sp_init_d = sp_init_q;

    case (state_q)
      I_PC: if (accept) begin
        if (s_if.word_i[WordW-1:AddrW] != '0) begin
          state_d = ERR;
        end else begin
          pc_load_d = 1'b1;
          pc_init_d = s_if.word_i;
          ptr_d     = s_if.word_i[AddrW-1:0];
          state_d   = I_CNT;
        end
      end
      I_CNT: if (accept) begin
        // Image must fit below the top of instruction memory.
        if (ChkW'(ptr_q) + ChkW'({s_if.word_i, 2'b00}) > ChkW'(MemBytes)) begin
          state_d = ERR;
        end else begin
          n_d     = s_if.word_i;
          cnt_d   = '0;
          state_d = (s_if.word_i == '0) ? D_SP : I_WORD;
        end
      end
      I_WORD, D_WORD: if (accept) begin
        word_d  = s_if.word_i;
        bidx_d  = '0;
        state_d = (state_q == I_WORD) ? I_BYTE : D_BYTE;
      end
      I_BYTE: begin
        im_we_d = 1'b1;
        ptr_d   = ptr_q + AddrW'(1);
        bidx_d  = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          cnt_d   = cnt_q + WordW'(1);
          state_d = last_word ? D_SP : I_WORD;
        end
      end
      D_SP: if (accept) begin
        sp_load_d = 1'b1;
        sp_init_d = s_if.word_i;
        ptr_d     = '0;
        state_d   = D_CNT;
      end
      D_CNT: if (accept) begin
        if (s_if.word_i > WordW'(MaxDWords)) begin
          state_d = ERR;
        end else begin
          n_d     = s_if.word_i;
          cnt_d   = '0;
          state_d = (s_if.word_i == '0) ? TailState : D_WORD;
        end
      end
      D_BYTE: begin
        dm_we_d = 1'b1;
        ptr_d   = ptr_q + AddrW'(1);
        bidx_d  = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          cnt_d = cnt_q + WordW'(1);
          // A full 1 KiB image leaves no tail to clear.
          if (last_word) state_d = (ptr_q == AddrW'(MemBytes - 1)) ? DONE : TailState;
          else           state_d = D_WORD;
        end
      end
`ifdef LOADER_DM_CLEAR_EN
      D_CLEAR: begin
        dm_we_d   = 1'b1;
        dm_byte_d = '0;
        ptr_d     = ptr_q + AddrW'(1);
        if (ptr_q == AddrW'(MemBytes - 1)) state_d = DONE;
      end
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    ready_d     = (state_d == I_PC) || (state_d == I_CNT) || (state_d == I_WORD) ||
                  (state_d == D_SP) || (state_d == D_CNT) || (state_d == D_WORD);
    cpu_rst_n_d = (state_q == DONE);
    done_d      = (state_q == DONE);
    err_d       = (state_q == ERR);
  end

  assign s_if.word_ready_o = ready_q;
  assign im_we_o     = im_we_q;
  assign im_addr_o   = im_addr_q;
  assign im_byte_o   = im_byte_q;
  assign dm_we_o     = dm_we_q;
  assign dm_addr_o   = dm_addr_q;
  assign dm_byte_o   = dm_byte_q;
  assign pc_load_o   = pc_load_q;
  assign pc_init_o   = pc_init_q;
  assign sp_load_o   = sp_load_q;
  assign sp_init_o   = sp_init_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: expected writes/strobes queued at stimulus, popped by a monitor.
module tb_image_loader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        im_we_o, dm_we_o, pc_load_o, sp_load_o, cpu_rst_n_o, done_o, err_o;
  logic [9:0]  im_addr_o, dm_addr_o;
  logic [7:0]  im_byte_o, dm_byte_o;
  logic [31:0] pc_init_o, sp_init_o;

  image_loader_if bus();

  image_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_if(bus),
    .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_byte_o(im_byte_o),
    .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_byte_o(dm_byte_o),
    .pc_load_o(pc_load_o), .pc_init_o(pc_init_o),
    .sp_load_o(sp_load_o), .sp_init_o(sp_init_o),
    .cpu_rst_n_o(cpu_rst_n_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [17:0] im_q[$];
  logic [17:0] dm_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] sp_q[$];
  bit          both_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (im_we_o && dm_we_o) both_we = 1'b1;
      if (im_we_o) begin
        if (im_q.size() == 0) unexpected("im_write", {im_addr_o, im_byte_o});
        else check("im_write", {im_addr_o, im_byte_o}, im_q.pop_front());
      end
      if (dm_we_o) begin
        if (dm_q.size() == 0) unexpected("dm_write", {dm_addr_o, dm_byte_o});
        else check("dm_write", {dm_addr_o, dm_byte_o}, dm_q.pop_front());
      end
      if (pc_load_o) begin
        if (pc_q.size() == 0) unexpected("pc_load", pc_init_o);
        else check("pc_load", pc_init_o, pc_q.pop_front());
      end
      if (sp_load_o) begin
        if (sp_q.size() == 0) unexpected("sp_load", sp_init_o);
        else check("sp_load", sp_init_o, sp_q.pop_front());
      end
    end
  end

  task automatic flush();
    im_q.delete(); dm_q.delete(); pc_q.delete(); sp_q.delete();
  endtask

  task automatic do_reset();
    bus.word_valid_i = 1'b0;
    rst_i = 1'b0;
    flush();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic push_word(input bit is_dm, input int base, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (is_dm) dm_q.push_back({10'(base + k), w[31-8*k -: 8]});
      else       im_q.push_back({10'(base + k), w[31-8*k -: 8]});
    end
  endtask

  task automatic push_clear(input int from);
`ifdef LOADER_DM_CLEAR_EN
    for (int a = from; a < 1024; a++) dm_q.push_back({10'(a), 8'h00});
`else
    if (from < 0) $display("push_clear: negative start %0d", from);
`endif
  endtask

  task automatic send(input logic [31:0] w, input int stall);
    int budget;
    budget = 200;
    repeat (stall) @(negedge clk_i);
    bus.word_i = w;
    bus.word_valid_i = 1'b1;
    while (!bus.word_ready_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) unexpected("send_timeout", w);
    else @(negedge clk_i);
    bus.word_valid_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int budget;
    budget = 4000;
    while (!done_o && !err_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) unexpected({name, "_end_timeout"}, 0);
    @(negedge clk_i);
  endtask

  task automatic check_done(input string name);
    wait_end(name);
    check({name, "_done"}, done_o, 1'b1);
    check({name, "_cpu_rst_n"}, cpu_rst_n_o, 1'b1);
    check({name, "_err"}, err_o, 1'b0);
    check({name, "_ready"}, bus.word_ready_o, 1'b0);
    check({name, "_pending"}, im_q.size() + dm_q.size() + pc_q.size() + sp_q.size(), 0);
  endtask

  task automatic check_err(input string name);
    wait_end(name);
    check({name, "_err"}, err_o, 1'b1);
    check({name, "_cpu_rst_n"}, cpu_rst_n_o, 1'b0);
    check({name, "_done"}, done_o, 1'b0);
    check({name, "_ready"}, bus.word_ready_o, 1'b0);
    check({name, "_pending"}, im_q.size() + dm_q.size() + pc_q.size() + sp_q.size(), 0);
  endtask

  // PC 0x10, two instruction words, SP 0x400, two data words.
  task automatic run_full(input int stall, input string name);
    pc_q.push_back(32'h0000_0010);
    send(32'h0000_0010, stall);
    send(32'd2, stall);
    push_word(1'b0, 16'h10, 32'h2008_0005);
    send(32'h2008_0005, stall);
    push_word(1'b0, 16'h14, 32'h8C09_0004);
    send(32'h8C09_0004, stall);
    sp_q.push_back(32'h0000_0400);
    send(32'h0000_0400, stall);
    send(32'd2, stall);
    push_word(1'b1, 0, 32'h1122_3344);
    send(32'h1122_3344, stall);
    push_word(1'b1, 4, 32'hAABB_CCDD);
    push_clear(8);
    send(32'hAABB_CCDD, stall);
    check_done(name);
  endtask

  initial begin
    int budget;
    bus.word_i = '0;
    bus.word_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_outputs", {im_we_o, dm_we_o, pc_load_o, sp_load_o, done_o, err_o, cpu_rst_n_o}, 7'd0);
    check("rst_ready", bus.word_ready_o, 1'b0);
    check("rst_pc_init", pc_init_o, 32'd0);
    check("rst_sp_init", sp_init_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Minimal image: one instruction word, empty data image.
    pc_q.push_back(32'd0);
    send(32'd0, 0);
    send(32'd1, 0);
    push_word(1'b0, 0, 32'h2008_0005);
    send(32'h2008_0005, 0);
    sp_q.push_back(32'h0000_0400);
    send(32'h0000_0400, 0);
    push_clear(0);
    send(32'd0, 0);
    check_done("basic");

    do_reset();
    run_full(0, "full");
    do_reset();
    run_full(3, "stall");

    // Instruction image ending exactly at the top of memory is legal.
    do_reset();
    pc_q.push_back(32'h0000_03F8);
    send(32'h0000_03F8, 0);
    send(32'd2, 0);
    push_word(1'b0, 10'h3F8, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 0);
    push_word(1'b0, 10'h3FC, 32'h0102_0304);
    send(32'h0102_0304, 0);
    sp_q.push_back(32'h0000_0100);
    send(32'h0000_0100, 0);
    push_clear(0);
    send(32'd0, 0);
    check_done("top_fit");

    do_reset();
    pc_q.push_back(32'h0000_03FC);
    send(32'h0000_03FC, 0);
    send(32'd2, 0);
    check_err("im_overflow");

    do_reset();
    send(32'h0000_0400, 0);
    check_err("pc_high_bits");

    do_reset();
    pc_q.push_back(32'd0);
    send(32'd0, 0);
    send(32'd0, 0);
    sp_q.push_back(32'h0000_0400);
    send(32'h0000_0400, 0);
    send(32'd257, 0);
    check_err("nd_257");

    // Abort during the second byte-write cycle of a fresh load.
    do_reset();
    pc_q.push_back(32'd0);
    send(32'd0, 0);
    send(32'd1, 0);
    push_word(1'b0, 0, 32'h2008_0005);
    send(32'h2008_0005, 0);
    budget = 50;
    while (!im_we_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) unexpected("abort_wait_timeout", 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("abort_outputs", {im_we_o, dm_we_o, pc_load_o, sp_load_o, done_o, err_o, cpu_rst_n_o}, 7'd0);
    check("abort_ready", bus.word_ready_o, 1'b0);
    check("abort_pc_init", pc_init_o, 32'd0);
    flush();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    run_full(0, "reload");

    check("we_exclusive", both_we, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 clk_i  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-low.
REQ-003 word_i  input  32  image word stream: instruction image, then data image, big-endian words.
REQ-004 word_valid_i / word_ready_o  input/output  1  stream handshake; a word transfers on a rising edge with both high.
REQ-005 im_we_o, im_addr_o[9:0], im_byte_o[7:0]  output  instruction-memory byte write port.
REQ-006 dm_we_o, dm_addr_o[9:0], dm_byte_o[7:0]  output  data-memory byte write port.
REQ-007 pc_load_o, pc_init_o[31:0]  output  one-cycle PC load strobe and value.
REQ-008 sp_load_o, sp_init_o[31:0]  output  one-cycle register-$29 load strobe and value.
REQ-009 cpu_rst_n_o  output  1  active-low CPU reset; held low until load completes.
REQ-010 done_o, err_o  output  1  sticky load-complete and load-error flags.

Function
REQ-011 State machine SHALL use the states I_PC, I_CNT, I_WORD, I_BYTE, D_SP, D_CNT, D_WORD, D_BYTE, D_CLEAR, DONE, ERR.
REQ-012 word_ready_o SHALL be high only in I_PC, I_CNT, I_WORD, D_SP, D_CNT and D_WORD.
REQ-013 I_PC: the accepted word SHALL drive pc_init_o and pulse pc_load_o for one cycle. It SHALL also set the instruction byte pointer to word[9:0]. Next state is I_CNT.
REQ-014 I_CNT: the accepted word is N_I. Next state is I_WORD if N_I>0, otherwise D_SP.
REQ-015 I_WORD: accept one word and go to I_BYTE. I_BYTE SHALL emit 4 bytes, one per cycle, with im_we_o high.
REQ-016 I_BYTE byte order SHALL be word[31:24], [23:16], [15:8], [7:0] at pointer+0..+3. The pointer then advances by 4.
REQ-017 After the N_I-th word, the next state SHALL be D_SP; otherwise it returns to I_WORD.
REQ-018 D_SP: the accepted word SHALL drive sp_init_o and pulse sp_load_o for one cycle. Next state is D_CNT.
REQ-019 D_CNT: the accepted word is N_D. Next state is D_WORD if N_D>0, otherwise D_CLEAR (or DONE if clear is disabled).
REQ-020 D_WORD/D_BYTE SHALL behave as I_WORD/I_BYTE on the dm port, starting at address 0, same byte order.
REQ-021 Error checks, each sending the block to ERR:
- PC header word[31:10] nonzero;
- PC+4*N_I > 1024;
- N_D > 256.
REQ-022 Each check SHALL be evaluated in the cycle its header word is accepted; no memory write is issued for that image.
REQ-023 ERR SHALL set err_o, keep word_ready_o low and keep cpu_rst_n_o low until reset.
REQ-024 DONE SHALL set done_o and drive cpu_rst_n_o high the cycle after entry. It SHALL remain there until reset.
REQ-025 Counters: word count 32-bit with compare against the latched N; byte pointer 10-bit. Wrap is impossible after the REQ-021 checks.
REQ-026 im_we_o and dm_we_o SHALL never be high in the same cycle.
REQ-027 Byte emission SHALL ignore word_valid_i; stalls on word_valid_i occur only in the accepting states.

Reset
REQ-028 When rst_i is low:
- state SHALL be I_PC;
- all counters SHALL be 0;
- all strobes, write enables, done_o and err_o SHALL be 0;
- cpu_rst_n_o SHALL be 0;
- pc_init_o and sp_init_o SHALL be 0.
REQ-029 Reset asserted mid-load SHALL abort immediately; the next load restarts at I_PC. Partial memory contents are not restored.

Configuration
REQ-030 LOADER_DM_CLEAR_EN defined: D_CLEAR SHALL write 0x00 to dm addresses 4*N_D..1023, one byte per cycle, then go to DONE.
REQ-031 LOADER_DM_CLEAR_EN undefined: D_CLEAR SHALL not exist; the data image's last byte (or N_D=0) goes directly to DONE.

Verification
REQ-032 Stream 0x00000000, 1, 0x20080005, 0x00000400, 0 -> im bytes 20,08,00,05 at 0..3. pc_load_o pulses with 0; sp_load_o pulses with 0x400.
REQ-033 Data image N_D=2, words 0x11223344, 0xAABBCCDD -> dm bytes 11,22,33,44,AA,BB,CC,DD at 0..7. With LOADER_DM_CLEAR_EN, bytes 8..1023 are written 0, then done_o=1 and cpu_rst_n_o=1.
REQ-034 Pulse word_valid_i low for 3 cycles between every word -> memory contents identical to REQ-032/033; no write occurs while stalled in an accepting state.
REQ-035 PC header 0x000003FC with N_I=2 -> err_o=1; no im write; cpu_rst_n_o stays 0.
REQ-036 N_D=257 -> err_o=1. rst_i low at the 2nd I_BYTE cycle of a fresh load -> all outputs take reset values immediately; a reload completes normally.
